// File: rtl/ssd1306_spi_sink.sv
`default_nettype none
// ============================================================================
// Module      : ssd1306_spi_sink
// Description : Receive side of the 4-wire SSD1306 OLED SPI bus. Oversamples
//               the bus in the clk domain and deserialises bytes MSB-first.
//               Decodes the command subset the driver emits and turns data
//               bytes into framebuffer writes using horizontal addressing.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd1306_spi_sink #(
    parameter int COLS        = 128,
    parameter int PAGES       = 8,
    parameter int SYNC_STAGES = 2,
    localparam int CW         = $clog2(COLS),
    localparam int PW         = $clog2(PAGES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sclk_i,
    input  logic          sdin_i,
    input  logic          cs_i,
    input  logic          dc_i,
    input  logic          res_i,
    output logic          byte_valid_o,
    output logic [7:0]    byte_o,
    output logic          byte_dc_o,
    output logic          pix_we_o,
    output logic [CW-1:0] pix_col_o,
    output logic [PW-1:0] pix_page_o,
    output logic [7:0]    pix_data_o,
    output logic          display_on_o,
    output logic [7:0]    contrast_o,
    output logic          proto_err_o
);

    localparam logic [CW-1:0] c_COL_LAST  = CW'(COLS - 1);
    localparam logic [PW-1:0] c_PAGE_LAST = PW'(PAGES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARG1 = 2'd1,
        S_ARG2 = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_sdin_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_dc_sync;
    logic [SYNC_STAGES-1:0] r_res_sync;
    logic                   r_sclk_prev;

    logic w_sclk_s;
    logic w_sdin_s;
    logic w_cs_s;
    logic w_dc_s;
    logic w_res_s;
    logic w_sclk_rise;
    logic w_rst;

    // Synchronisers are cleared only by the system reset so that res_i can
    // itself be observed; cs and res park at their inactive (high) level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_sdin_sync <= '0;
            r_cs_sync   <= '1;
            r_dc_sync   <= '0;
            r_res_sync  <= '1;
            r_sclk_prev <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
            r_sdin_sync <= {r_sdin_sync[SYNC_STAGES-2:0], sdin_i};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   cs_i};
            r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0],   dc_i};
            r_res_sync  <= {r_res_sync[SYNC_STAGES-2:0],  res_i};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_sdin_s    = r_sdin_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_dc_s      = r_dc_sync[SYNC_STAGES-1];
    assign w_res_s     = r_res_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
    assign w_rst       = reset | ~w_res_s;

    // ------------------------------------------------------------------
    // Byte deserialiser
    // ------------------------------------------------------------------
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       w_frame_err;

    // A deselect in the middle of a byte is a framing error.
    assign w_frame_err = w_cs_s & (r_bit_cnt != 3'd0);

    // Shift in one bit per sclk rise; publish the byte after the 8th bit.
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            byte_valid_o <= 1'b0;
            byte_o       <= 8'h00;
            byte_dc_o    <= 1'b0;
        end else begin
            byte_valid_o <= 1'b0;
            if (w_cs_s) begin
                r_bit_cnt <= 3'd0;
            end else if (w_sclk_rise) begin
                r_shift   <= {r_shift[6:0], w_sdin_s};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    byte_valid_o <= 1'b1;
                    byte_o       <= {r_shift[6:0], w_sdin_s};
                    byte_dc_o    <= w_dc_s;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Command decoder and framebuffer address generator
    // ------------------------------------------------------------------
    state_t        r_state;
    logic [7:0]    r_opcode;
    logic [CW-1:0] r_col_arg;
    logic [PW-1:0] r_page_arg;
    logic [CW-1:0] r_col_start;
    logic [CW-1:0] r_col_end;
    logic [CW-1:0] r_col_ptr;
    logic [PW-1:0] r_page_start;
    logic [PW-1:0] r_page_end;
    logic [PW-1:0] r_page_ptr;

    // Decode each received byte the cycle after it is published.
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state      <= S_IDLE;
            r_opcode     <= 8'h00;
            r_col_arg    <= '0;
            r_page_arg   <= '0;
            r_col_start  <= '0;
            r_col_end    <= c_COL_LAST;
            r_col_ptr    <= '0;
            r_page_start <= '0;
            r_page_end   <= c_PAGE_LAST;
            r_page_ptr   <= '0;
            pix_we_o     <= 1'b0;
            pix_col_o    <= '0;
            pix_page_o   <= '0;
            pix_data_o   <= 8'h00;
            display_on_o <= 1'b0;
            contrast_o   <= 8'h7F;
            proto_err_o  <= 1'b0;
        end else begin
            pix_we_o <= 1'b0;
            if (w_frame_err) begin
                proto_err_o <= 1'b1;
            end
            if (byte_valid_o) begin
                if (byte_dc_o) begin
                    // Pixel data; an unfinished command is abandoned.
                    if (r_state != S_IDLE) begin
                        proto_err_o <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                    pix_we_o   <= 1'b1;
                    pix_col_o  <= r_col_ptr;
                    pix_page_o <= r_page_ptr;
                    pix_data_o <= byte_o;
                    if (r_col_ptr == r_col_end) begin
                        r_col_ptr <= r_col_start;
                        if (r_page_ptr == r_page_end) begin
                            r_page_ptr <= r_page_start;
                        end else begin
                            r_page_ptr <= r_page_ptr + PW'(1);
                        end
                    end else begin
                        r_col_ptr <= r_col_ptr + CW'(1);
                    end
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            case (byte_o)
                                8'hAE: display_on_o <= 1'b0;
                                8'hAF: display_on_o <= 1'b1;
                                8'h21, 8'h22, 8'h81, 8'h20, 8'hA8, 8'hD3,
                                8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D: begin
                                    r_opcode <= byte_o;
                                    r_state  <= S_ARG1;
                                end
                                default: ;
                            endcase
                        end
                        S_ARG1: begin
                            if (r_opcode == 8'h21 || r_opcode == 8'h22) begin
                                r_col_arg  <= byte_o[CW-1:0];
                                r_page_arg <= byte_o[PW-1:0];
                                r_state    <= S_ARG2;
                            end else begin
                                if (r_opcode == 8'h81) begin
                                    contrast_o <= byte_o;
                                end
                                r_state <= S_IDLE;
                            end
                        end
                        S_ARG2: begin
                            if (r_opcode == 8'h21) begin
                                if (r_col_arg <= byte_o[CW-1:0]) begin
                                    r_col_start <= r_col_arg;
                                    r_col_end   <= byte_o[CW-1:0];
                                    r_col_ptr   <= r_col_arg;
                                end else begin
                                    proto_err_o <= 1'b1;
                                end
                            end else begin
                                if (r_page_arg <= byte_o[PW-1:0]) begin
                                    r_page_start <= r_page_arg;
                                    r_page_end   <= byte_o[PW-1:0];
                                    r_page_ptr   <= r_page_arg;
                                end else begin
                                    proto_err_o <= 1'b1;
                                end
                            end
                            r_state <= S_IDLE;
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire
